// File: rtl/typed_accum.sv
// Multi-channel accumulator: tagged beats over valid/ready are added into one of NCH
// per-channel sums (signed/unsigned, wrap/saturate), with a registered result per beat.
module typed_accum #(
  parameter int DW     = 8,
  parameter int AW     = 65,
  parameter int NCH    = 4,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [$clog2(NCH)-1:0] in_ch,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [AW-1:0]          out_acc,
  output logic                   out_ovf,
  output logic [31:0]            beat_count
);

  logic [NCH-1:0][AW-1:0] acc_q;
  logic [NCH-1:0]         ovf_q;

  logic          accept;
  logic [AW-1:0] ext;
  logic [AW-1:0] cur;
  logic [AW:0]   sum;
  logic          add_ovf;
  logic [AW-1:0] sat_val;
  logic [AW-1:0] nxt_acc;
  logic          nxt_ovf;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Datapath for the addressed channel; the stored value from the previous edge is
  // always current, so back-to-back beats to one channel need no forwarding.
  always_comb begin
    ext = '0;
    if (SIGNED) ext = {AW{in_data[DW-1]}};
    ext[DW-1:0] = in_data;

    cur = acc_q[in_ch];
    sum = {1'b0, cur} + {1'b0, ext};

    if (SIGNED)
      add_ovf = (cur[AW-1] == ext[AW-1]) && (sum[AW-1] != cur[AW-1]);
    else
      add_ovf = sum[AW];

    sat_val = '1;
    if (SIGNED) begin
      if (cur[AW-1]) begin
        sat_val         = '0;
        sat_val[AW-1]   = 1'b1;
      end else begin
        sat_val[AW-1]   = 1'b0;
      end
    end

    if (in_clear) begin
      nxt_acc = ext;
      nxt_ovf = 1'b0;
    end else begin
      nxt_ovf = ovf_q[in_ch] | add_ovf;
      nxt_acc = (add_ovf && SAT) ? sat_val : sum[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q      <= '0;
      ovf_q      <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
      beat_count <= '0;
    end else if (accept) begin
      acc_q[in_ch] <= nxt_acc;
      ovf_q[in_ch] <= nxt_ovf;
      out_valid    <= 1'b1;
      out_ch       <= in_ch;
      out_acc      <= nxt_acc;
      out_ovf      <= nxt_ovf;
      beat_count   <= beat_count + 32'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_typed_accum.sv
// Directed bench for typed_accum: one wide signed-saturating instance plus three
// 8-bit variants sharing a single stimulus bus, checked with immediate assertions.
module tb_typed_accum;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_data;
  logic       in_clear;
  logic       out_ready;

  logic        d_in_ready, d_out_valid, d_out_ovf;
  logic [1:0]  d_out_ch;
  logic [64:0] d_out_acc;
  logic [31:0] d_beat_count;

  logic        s8_in_ready, s8_out_valid, s8_out_ovf;
  logic [1:0]  s8_out_ch;
  logic [7:0]  s8_out_acc;
  logic [31:0] s8_beat_count;

  logic        u8w_in_ready, u8w_out_valid, u8w_out_ovf;
  logic [1:0]  u8w_out_ch;
  logic [7:0]  u8w_out_acc;
  logic [31:0] u8w_beat_count;

  logic        u8s_in_ready, u8s_out_valid, u8s_out_ovf;
  logic [1:0]  u8s_out_ch;
  logic [7:0]  u8s_out_acc;
  logic [31:0] u8s_beat_count;

  int checks = 0;
  int errors = 0;

  typed_accum u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_clear(in_clear),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_ch(d_out_ch),
    .out_acc(d_out_acc), .out_ovf(d_out_ovf), .beat_count(d_beat_count)
  );

  typed_accum #(.DW(8), .AW(8), .NCH(4), .SIGNED(1'b1), .SAT(1'b1)) u_s8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s8_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_clear(in_clear),
    .out_valid(s8_out_valid), .out_ready(out_ready), .out_ch(s8_out_ch),
    .out_acc(s8_out_acc), .out_ovf(s8_out_ovf), .beat_count(s8_beat_count)
  );

  typed_accum #(.DW(8), .AW(8), .NCH(4), .SIGNED(1'b0), .SAT(1'b0)) u_u8w (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(u8w_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_clear(in_clear),
    .out_valid(u8w_out_valid), .out_ready(out_ready), .out_ch(u8w_out_ch),
    .out_acc(u8w_out_acc), .out_ovf(u8w_out_ovf), .beat_count(u8w_beat_count)
  );

  typed_accum #(.DW(8), .AW(8), .NCH(4), .SIGNED(1'b0), .SAT(1'b1)) u_u8s (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(u8s_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_clear(in_clear),
    .out_valid(u8s_out_valid), .out_ready(out_ready), .out_ch(u8s_out_ch),
    .out_acc(u8s_out_acc), .out_ovf(u8s_out_ovf), .beat_count(u8s_beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus and leaves the bench 1 ns past the rising edge.
  task automatic apply_stimulus(input logic v, input logic [1:0] ch, input logic [7:0] data,
                                input logic clr, input logic ordy);
    in_valid  = v;
    in_ch     = ch;
    in_data   = data;
    in_clear  = clr;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b1;
    check_output("rst_valid", d_out_valid, 65'd0);
    check_output("rst_acc", d_out_acc, 65'd0);
    check_output("rst_count", d_beat_count, 65'd0);
    check_output("rst_ready", d_in_ready, 65'd1);

    $display("[TB] accumulate 5, 3, -2 on ch1");
    apply_stimulus(1'b1, 2'd1, 8'd5, 1'b0, 1'b1);
    check_output("t1_valid", d_out_valid, 65'd1);
    check_output("t1_ch", d_out_ch, 65'd1);
    check_output("t1_acc5", d_out_acc, 65'd5);
    apply_stimulus(1'b1, 2'd1, 8'd3, 1'b0, 1'b1);
    check_output("t1_acc8", d_out_acc, 65'd8);
    apply_stimulus(1'b1, 2'd1, 8'hFE, 1'b0, 1'b1);
    check_output("t1_acc6", d_out_acc, 65'd6);
    check_output("t1_ovf", d_out_ovf, 65'd0);
    check_output("t1_count", d_beat_count, 65'd3);
    check_output("t1_u8w_acc", u8w_out_acc, 65'd6);
    check_output("t1_u8w_ovf", u8w_out_ovf, 65'd1);
    check_output("t1_u8s_acc", u8s_out_acc, 65'd255);
    for (int c = 0; c < 4; c++) begin
      if (c != 1) begin
        apply_stimulus(1'b1, 2'(c), 8'd0, 1'b0, 1'b1);
        check_output($sformatf("t1_other_ch%0d", c), d_out_acc, 65'd0);
      end
    end
    check_output("t1_count6", d_beat_count, 65'd6);

    $display("[TB] wide signed readback on ch2");
    apply_stimulus(1'b1, 2'd2, 8'h80, 1'b1, 1'b1);
    check_output("t2_m128", d_out_acc, 65'h1FFFFFFFFFFFFFF80);
    apply_stimulus(1'b1, 2'd2, 8'hFF, 1'b0, 1'b1);
    check_output("t2_m129", d_out_acc, 65'h1FFFFFFFFFFFFFF7F);
    check_output("t2_msb", d_out_acc[64], 65'd1);
    check_output("t2_ovf", d_out_ovf, 65'd0);

    $display("[TB] 8-bit signed saturation on ch0");
    apply_stimulus(1'b1, 2'd0, 8'd100, 1'b1, 1'b1);
    check_output("t3_clr", s8_out_acc, 65'd100);
    apply_stimulus(1'b1, 2'd0, 8'd100, 1'b0, 1'b1);
    check_output("t3_sat", s8_out_acc, 65'd127);
    check_output("t3_ovf", s8_out_ovf, 65'd1);
    apply_stimulus(1'b1, 2'd0, 8'hF6, 1'b0, 1'b1);
    check_output("t3_sub", s8_out_acc, 65'd117);
    check_output("t3_sticky", s8_out_ovf, 65'd1);
    apply_stimulus(1'b1, 2'd0, 8'd0, 1'b1, 1'b1);
    check_output("t3_clr0", s8_out_acc, 65'd0);
    check_output("t3_ovf_clr", s8_out_ovf, 65'd0);

    $display("[TB] 8-bit unsigned wrap and saturate on ch3");
    apply_stimulus(1'b1, 2'd3, 8'd200, 1'b1, 1'b1);
    apply_stimulus(1'b1, 2'd3, 8'd100, 1'b0, 1'b1);
    check_output("t4_wrap", u8w_out_acc, 65'd44);
    check_output("t4_wrap_ovf", u8w_out_ovf, 65'd1);
    check_output("t4_sat", u8s_out_acc, 65'd255);
    check_output("t4_sat_ovf", u8s_out_ovf, 65'd1);
    check_output("t4_signed", s8_out_acc, 65'd44);
    check_output("t4_signed_ovf", s8_out_ovf, 65'd0);
    check_output("t4_count", d_beat_count, 65'd14);

    $display("[TB] backpressure on ch1");
    apply_stimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    check_output("t5_idle_valid", d_out_valid, 65'd0);
    apply_stimulus(1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
    check_output("t5_acc7", d_out_acc, 65'd7);
    check_output("t5_count15", d_beat_count, 65'd15);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t5_stall_ready%0d", i), d_in_ready, 65'd0);
      apply_stimulus(1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
      check_output($sformatf("t5_stall_acc%0d", i), d_out_acc, 65'd7);
      check_output($sformatf("t5_stall_count%0d", i), d_beat_count, 65'd15);
      check_output($sformatf("t5_stall_valid%0d", i), d_out_valid, 65'd1);
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 2'd1, 8'd1, 1'b0, 1'b1);
      check_output($sformatf("t5_resume_acc%0d", i), d_out_acc, 65'(8 + i));
      check_output($sformatf("t5_resume_count%0d", i), d_beat_count, 65'(16 + i));
    end

    $display("[TB] reset while holding a result");
    apply_stimulus(1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
    check_output("t6_hold_acc", d_out_acc, 65'd10);
    check_output("t6_hold_ready", d_in_ready, 65'd0);
    rstn = 1'b0;
    apply_stimulus(1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
    rstn = 1'b1;
    check_output("t6_rst_valid", d_out_valid, 65'd0);
    check_output("t6_rst_count", d_beat_count, 65'd0);
    check_output("t6_rst_acc", d_out_acc, 65'd0);
    apply_stimulus(1'b1, 2'd1, 8'd7, 1'b0, 1'b1);
    check_output("t6_add7", d_out_acc, 65'd7);
    check_output("t6_ovf", d_out_ovf, 65'd0);
    check_output("t6_count1", d_beat_count, 65'd1);
    apply_stimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/typed_accum.md
Name: typed_accum

Overview:
Parametrised multi-channel accumulator used as the next-generation type-exercising DUT for the testbench framework. Accepts tagged data beats over a valid/ready handshake and adds each beat into one of NCH per-channel accumulators, in signed or unsigned mode, with either wrap or saturate overflow. It emits the updated sum per beat. The default accumulator width is deliberately over 64 bits, so the bench's wide-value and signed-value access paths are exercised.

Parameters:
DW, 8, input data width (1..64)
AW, 65, accumulator width; must be >= DW
NCH, 4, channel count (power of two, >= 2)
SIGNED, 1, 1 = two's-complement data and accumulators, 0 = unsigned
SAT, 1, 1 = saturate on overflow, 0 = wrap modulo 2^AW

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  reset, synchronous, active-low
in_valid  input  1  input beat present
in_ready  output  1  block can accept beat
in_ch  input  $clog2(NCH)  target channel
in_data  input  DW  operand, interpreted per SIGNED
in_clear  input  1  beat starts a new sum (replace instead of add)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_ch  output  $clog2(NCH)  channel of result
out_acc  output  AW  channel accumulator after update
out_ovf  output  1  channel sticky overflow flag after update
beat_count  output  32  total accepted beats, wraps 2^32-1 -> 0

Behaviour:
- Reset (rstn low at posedge) has priority over everything. All accumulators go to 0, all ovf flags to 0, out_valid=0, out_ch=0, out_acc=0, out_ovf=0, beat_count=0. A pending output is dropped.
- in_ready = !out_valid || out_ready (combinational). An input beat is accepted when in_valid && in_ready.
- Accept at edge N: the channel state updates at N, and out_valid=1 with the new values is visible after N (1-cycle latency).
- If no beat is accepted and out_ready=1, out_valid clears. Full throughput is 1 beat/cycle.
- While out_valid && !out_ready, out_ch, out_acc and out_ovf hold stable, and in_ready=0.
- Operand extension: sign-extend in_data to AW if SIGNED=1, else zero-extend.
- in_clear=1: acc[ch] = ext(in_data) and ovf[ch] = 0; no overflow is possible.
- in_clear=0: the sum is computed in AW+1 bits.
  - Unsigned overflow = carry out of bit AW-1.
  - Signed overflow = operands have equal sign and the result sign differs.
  - On overflow: ovf[ch] is set (sticky until clear or reset).
  - SAT=1: acc = 2^AW-1 (unsigned), 2^(AW-1)-1 (signed positive), or -2^(AW-1) (signed negative).
  - SAT=0: acc = low AW bits of the sum.
- Back-to-back beats to the same channel use the value written on the previous edge; there is no hazard or stall.
- Other channels are unaffected by a beat.
- beat_count increments by 1 per accepted beat only.
- in_valid with in_ready=0: nothing changes. The source must hold the beat, and the block does not sample it.
- out_ready with out_valid=0 has no effect.

Test Plan:
- Defaults, reset, then 3 beats on ch1: 5, 3, -2 (8'hFE) with out_ready=1. Results 5, 8, 6 on consecutive cycles, out_ovf=0, beat_count=3, ch0/2/3 unchanged at 0.
- Defaults, clear beat ch2 = -128, then +(-1) x1. out_acc = 65-bit -128, then -129 (all 65 bits sign-correct, bit 64 = 1). Confirms >64-bit signed readback.
- AW=8, SIGNED=1, SAT=1: clear 100 then add 100 on ch0. out_acc = 127, out_ovf=1. Next add -10 gives 117 with ovf still 1. A clear beat of 0 gives acc 0, ovf 0.
- AW=8, SIGNED=0, SAT=0: clear 200 then add 100. out_acc = 44, out_ovf=1. With SAT=1 the same sequence gives 255.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1. Exactly one beat is accepted, in_ready=0 and out_* stable for 4 cycles. Then out_ready=1 resumes 1 beat/cycle with no beat lost or duplicated (beat_count matches).
- Reset mid-stream: assert rstn=0 for 1 cycle while out_valid=1 and holding. Next cycle shows out_valid=0, beat_count=0, and a subsequent add of 7 on that channel yields 7.
